rf_port_arbiter: RTL and testbench
==================================

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameter: addrsize, default 5, register address width.
REQ-002 Parameter: nreq, fixed at 3, number of requesters, indexed r=0..2.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 hold  in  1  when 1, no new grants are issued.
REQ-006 rreq  in  3  read request, one bit per requester.
REQ-007 raddr  in  3*addrsize  read address per requester.
REQ-008 rgnt  out  3  read grant, combinational, same cycle as accepted rreq.
REQ-009 rvalid  out  3  read data valid per requester, registered.
REQ-010 rdata  out  3*32  read data per requester.
REQ-011 wreq  in  3  write request per requester.
REQ-012 waddr  in  3*addrsize  write address per requester.
REQ-013 wdata  in  3*32  write data per requester.
REQ-014 wgnt  out  3  write grant, combinational.
REQ-015 ra0, ra1  out  addrsize each  register-file read addresses.
REQ-016 read  out  2  register-file read enables, bit p for port p.
REQ-017 rd0, rd1  in  32 each  register-file read data, valid the cycle after read[p].
REQ-018 wa0, wa1  out  addrsize each  register-file write addresses.
REQ-019 wd0, wd1  out  32 each  register-file write data.
REQ-020 write  out  2  register-file write enables.

Function
REQ-021 Handshake: requester holds rreq/raddr (wreq/waddr/wdata) stable until it sees its grant bit high at a posedge; the transfer completes on that edge.
REQ-022 At most one read grant and one write grant per requester per cycle; at most 2 read grants and 2 write grants total per cycle.
REQ-023 Read arbitration is round-robin from pointer rptr (0..2): scan r = rptr, rptr+1, rptr+2 mod 3; the first requesting r gets port 0 and the second gets port 1.
REQ-024 rptr updates at the edge to (last granted r + 1) mod 3; it is unchanged when no read is granted.
REQ-025 Write arbitration is identical, with independent pointer wptr, mapping onto wa0/wd0/write[0] and wa1/wd1/write[1].
REQ-026 Write-write conflict: if the two write candidates share an address, only the first in scan order is granted; the second is not granted, and wptr advances past the first only.
REQ-027 Unused port: read[p]/write[p]=0, with the address and data outputs driven to 0.
REQ-028 Read return: on a grant, the port-to-requester tag (2 bits plus a valid bit per port) is registered; next cycle rvalid[tag] is asserted and rdata[tag] receives rd0 or rd1 (latency 1 cycle from grant edge).
REQ-029 rvalid is a one-cycle pulse per granted read; rdata of non-valid requesters is held at its previous value.
REQ-030 Same-cycle read and write to one address: no forwarding; the read returns the pre-write value.
REQ-031 hold=1: rgnt, wgnt, read, and write are all 0 and pointers are frozen; rvalid for grants issued the prior cycle still completes.

Reset
REQ-032 While rst=0: rgnt=0, wgnt=0, read=0, write=0, rvalid=0, rdata=0, ra*/wa*/wd*=0, rptr=wptr=0, and tags invalid.
REQ-033 An in-flight read (granted the cycle before rst falls) is discarded; no rvalid follows reset release.
REQ-034 The first edge after rst rises may issue grants.

Verification
REQ-035 rreq=3'b111, rptr=0 -> rgnt=3'b011, ra0=raddr0, ra1=raddr1; next cycle rvalid=3'b011 with rdata0=rd0 and rdata1=rd1; rptr=2.
REQ-036 rreq held at 3'b111 for 3 cycles from reset -> grants 011, 101, 110; each requester receives 2 rvalid pulses.
REQ-037 wreq=3'b011, waddr0=waddr1=5 -> wgnt=3'b001, write=2'b01, wa0=5; next cycle wgnt=3'b010, wa0=5.
REQ-038 Write 0xDEADBEEF to reg 7 while reading reg 7 in the same cycle -> rdata returns the old value; a read the following cycle returns 0xDEADBEEF.
REQ-039 hold=1 with rreq=wreq=3'b111 -> no grants and pointers unchanged; a grant issued the cycle before hold rose still gives rvalid.
REQ-040 rst driven low between grant and return -> rvalid stays 0 and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter mapping three requesters onto a 2-read/2-write register file.
// Grants are combinational; read data returns one cycle later through a per-port tag.
module rf_port_arbiter #(
  parameter int addrsize = 5,
  parameter int nreq     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [nreq-1:0]          rreq,
  input  logic [nreq*addrsize-1:0] raddr,
  output logic [nreq-1:0]          rgnt,
  output logic [nreq-1:0]          rvalid,
  output logic [nreq*32-1:0]       rdata,
  input  logic [nreq-1:0]          wreq,
  input  logic [nreq*addrsize-1:0] waddr,
  input  logic [nreq*32-1:0]       wdata,
  output logic [nreq-1:0]          wgnt,
  output logic [addrsize-1:0]      ra0,
  output logic [addrsize-1:0]      ra1,
  output logic [1:0]               read,
  input  logic [31:0]              rd0,
  input  logic [31:0]              rd1,
  output logic [addrsize-1:0]      wa0,
  output logic [addrsize-1:0]      wa1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1,
  output logic [1:0]               write
);

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } tag_t;

  logic [1:0]          rptr_q, rptr_d;
  logic [1:0]          wptr_q, wptr_d;
  tag_t                rtag_q [2];
  tag_t                rtag_d [2];
  logic [31:0]         rdata_q [3];
  logic [31:0]         rdata_d [3];
  logic [addrsize-1:0] raddr_a [3];
  logic [addrsize-1:0] waddr_a [3];
  logic [31:0]         wdata_a [3];
  logic                en;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign en = rst & ~hold;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      raddr_a[r] = raddr[r*addrsize +: addrsize];
      waddr_a[r] = waddr[r*addrsize +: addrsize];
      wdata_a[r] = wdata[r*32 +: 32];
    end
  end

  always_comb begin : read_arb
    logic [1:0] idx;
    logic [1:0] cnt;
    rgnt      = '0;
    read      = '0;
    ra0       = '0;
    ra1       = '0;
    rptr_d    = rptr_q;
    rtag_d[0] = '0;
    rtag_d[1] = '0;
    idx       = rptr_q;
    cnt       = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (en && rreq[idx] && cnt != 2'd2) begin
        rgnt[idx]         = 1'b1;
        read[cnt[0]]      = 1'b1;
        rtag_d[cnt[0]]    = {1'b1, idx};
        if (cnt == 2'd0) ra0 = raddr_a[idx];
        else             ra1 = raddr_a[idx];
        rptr_d = inc3(idx);
        cnt    = cnt + 2'd1;
      end
      idx = inc3(idx);
    end
  end

  always_comb begin : write_arb
    logic [1:0] idx;
    logic       first;
    logic       stop;
    wgnt   = '0;
    write  = '0;
    wa0    = '0;
    wa1    = '0;
    wd0    = '0;
    wd1    = '0;
    wptr_d = wptr_q;
    idx    = wptr_q;
    first  = 1'b0;
    stop   = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (en && wreq[idx] && !stop) begin
        if (!first) begin
          wgnt[idx] = 1'b1;
          write[0]  = 1'b1;
          wa0       = waddr_a[idx];
          wd0       = wdata_a[idx];
          wptr_d    = inc3(idx);
          first     = 1'b1;
        end else begin
          // A second candidate hitting the same address is dropped, not skipped past.
          if (waddr_a[idx] != wa0) begin
            wgnt[idx] = 1'b1;
            write[1]  = 1'b1;
            wa1       = waddr_a[idx];
            wd1       = wdata_a[idx];
            wptr_d    = inc3(idx);
          end
          stop = 1'b1;
        end
      end
      idx = inc3(idx);
    end
  end

  always_comb begin
    rvalid = '0;
    for (int unsigned r = 0; r < 3; r++) rdata_d[r] = rdata_q[r];
    if (rtag_q[0].vld) begin
      rvalid[rtag_q[0].idx]  = 1'b1;
      rdata_d[rtag_q[0].idx] = rd0;
    end
    if (rtag_q[1].vld) begin
      rvalid[rtag_q[1].idx]  = 1'b1;
      rdata_d[rtag_q[1].idx] = rd1;
    end
    for (int unsigned r = 0; r < 3; r++) rdata[r*32 +: 32] = rdata_d[r];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      rtag_q[0] <= '0;
      rtag_q[1] <= '0;
      for (int unsigned r = 0; r < 3; r++) rdata_q[r] <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      rtag_q[0] <= rtag_d[0];
      rtag_q[1] <= rtag_d[1];
      for (int unsigned r = 0; r < 3; r++) rdata_q[r] <= rdata_d[r];
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter: grant/port checks per step, read returns
// checked by a queue-based monitor against a small register-file model.
module tb_rf_port_arbiter;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic [2:0]    rreq, wreq, rgnt, wgnt, rvalid;
  logic [3*AW-1:0] raddr, waddr;
  logic [95:0]   wdata, rdata;
  logic [AW-1:0] ra0, ra1, wa0, wa1;
  logic [1:0]    read, write;
  logic [31:0]   rd0 = '0, rd1 = '0, wd0, wd1;
  logic [31:0]   mem [32];

  typedef struct {
    int          r;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  rf_port_arbiter #(.addrsize(AW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .rreq(rreq), .raddr(raddr), .rgnt(rgnt), .rvalid(rvalid), .rdata(rdata),
    .wreq(wreq), .waddr(waddr), .wdata(wdata), .wgnt(wgnt),
    .ra0(ra0), .ra1(ra1), .read(read), .rd0(rd0), .rd1(rd1),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .write(write)
  );

  always #5 clk = ~clk;

  // Register file: data valid the cycle after read, reads see pre-write contents.
  always @(posedge clk) begin
    if (read[0])  rd0 <= mem[ra0];
    if (read[1])  rd1 <= mem[ra1];
    if (write[0]) mem[wa0] <= wd0;
    if (write[1]) mem[wa1] <= wd1;
  end

  function automatic logic [31:0] da(input int a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic set_r(input int a0, input int a1, input int a2);
    raddr = {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
  endtask

  task automatic set_w(input int a0, input int a1, input int a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    waddr = {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
    wdata = {d2, d1, d0};
  endtask

  task automatic step(input string nm, input logic [2:0] erg, input logic [2:0] ewg,
                      input logic [1:0] erd, input logic [1:0] ewr,
                      input logic [AW-1:0] era0, input logic [AW-1:0] era1,
                      input logic [AW-1:0] ewa0, input logic [AW-1:0] ewa1,
                      input logic [31:0] ewd0, input logic [31:0] ewd1);
    #1;
    chk({nm, ".rgnt"}, rgnt, erg);
    chk({nm, ".wgnt"}, wgnt, ewg);
    chk({nm, ".read"}, read, erd);
    chk({nm, ".write"}, write, ewr);
    chk({nm, ".ra"}, {ra0, ra1}, {era0, era1});
    chk({nm, ".wa"}, {wa0, wa1}, {ewa0, ewa1});
    chk({nm, ".wd0"}, wd0, ewd0);
    chk({nm, ".wd1"}, wd1, ewd1);
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    #1;
    chk({nm, ".rgnt"}, rgnt, '0);
    chk({nm, ".wgnt"}, wgnt, '0);
    chk({nm, ".rw_en"}, {read, write}, '0);
    chk({nm, ".rvalid"}, rvalid, '0);
    chk({nm, ".rdata"}, rdata, '0);
    chk({nm, ".addr"}, {ra0, ra1, wa0, wa1}, '0);
    chk({nm, ".wd"}, {wd0, wd1}, '0);
  endtask

  // Monitor: pops the expected return for every rvalid pulse, checks held rdata otherwise.
  initial begin
    logic [31:0] last [3];
    exp_t e;
    for (int r = 0; r < 3; r++) last[r] = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        for (int r = 0; r < 3; r++) last[r] = '0;
      end else begin
        for (int r = 0; r < 3; r++) begin
          if (rvalid[r]) begin
            n_chk++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_rvalid: requester %0d rdata %h, nothing expected", r, rdata[r*32 +: 32]);
            end else begin
              e = q.pop_front();
              if (e.r != r || rdata[r*32 +: 32] !== e.d) begin
                n_fail++;
                $display("FAIL read_return: got r%0d %h expected r%0d %h", r, rdata[r*32 +: 32], e.r, e.d);
              end
            end
            last[r] = rdata[r*32 +: 32];
          end else begin
            chk($sformatf("rdata_hold.r%0d", r), rdata[r*32 +: 32], last[r]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = da(i);
    rst  = 1'b0;
    hold = 1'b0;
    rreq = 3'b111;
    wreq = 3'b111;
    set_r(1, 2, 3);
    set_w(4, 5, 6, 32'h1, 32'h2, 32'h3);

    @(negedge clk);
    check_zero("reset");
    @(negedge clk);

    rst  = 1'b1;
    wreq = 3'b000;
    set_w(0, 0, 0, 0, 0, 0);
    push(0, da(1)); push(1, da(2));
    step("t1", 3'b011, 3'b000, 2'b11, 2'b00, 1, 2, 0, 0, 0, 0);
    push(0, da(1)); push(2, da(3));
    step("t2", 3'b101, 3'b000, 2'b11, 2'b00, 3, 1, 0, 0, 0, 0);
    push(1, da(2)); push(2, da(3));
    step("t3", 3'b110, 3'b000, 2'b11, 2'b00, 2, 3, 0, 0, 0, 0);

    rreq = 3'b000;
    set_r(0, 0, 0);
    set_w(5, 5, 0, 32'h1111_0000, 32'h2222_0000, 0);
    wreq = 3'b011;
    step("wconf1", 3'b000, 3'b001, 2'b00, 2'b01, 0, 0, 5, 0, 32'h1111_0000, 0);
    wreq = 3'b010;
    step("wconf2", 3'b000, 3'b010, 2'b00, 2'b01, 0, 0, 5, 0, 32'h2222_0000, 0);

    set_w(0, 0, 7, 0, 0, 32'hDEAD_BEEF);
    wreq = 3'b100;
    set_r(7, 0, 0);
    rreq = 3'b001;
    push(0, da(7));
    step("rw_same", 3'b001, 3'b100, 2'b01, 2'b01, 7, 0, 7, 0, 32'hDEAD_BEEF, 0);
    wreq = 3'b000;
    set_w(0, 0, 0, 0, 0, 0);
    set_r(0, 7, 0);
    rreq = 3'b010;
    push(1, 32'hDEAD_BEEF);
    step("r_after_w", 3'b010, 3'b000, 2'b01, 2'b00, 7, 0, 0, 0, 0, 0);
    set_r(0, 0, 5);
    rreq = 3'b100;
    push(2, 32'h2222_0000);
    step("r_reg5", 3'b100, 3'b000, 2'b01, 2'b00, 5, 0, 0, 0, 0, 0);

    set_r(4, 6, 0);
    rreq = 3'b011;
    push(0, da(4)); push(1, da(6));
    step("pre_hold", 3'b011, 3'b000, 2'b11, 2'b00, 4, 6, 0, 0, 0, 0);
    hold = 1'b1;
    set_r(1, 2, 3);
    rreq = 3'b111;
    set_w(8, 9, 10, 32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA);
    wreq = 3'b111;
    step("hold", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    hold = 1'b0;
    push(0, da(1)); push(2, da(3));
    step("post_hold", 3'b101, 3'b011, 2'b11, 2'b11, 3, 1, 8, 9, 32'h8888_8888, 32'h9999_9999);
    rreq = 3'b010;
    wreq = 3'b100;
    push(1, da(2));
    step("t12", 3'b010, 3'b100, 2'b01, 2'b01, 2, 0, 10, 0, 32'hAAAA_AAAA, 0);
    wreq = 3'b000;
    set_w(0, 0, 0, 0, 0, 0);
    set_r(8, 9, 10);
    rreq = 3'b111;
    push(0, 32'h8888_8888); push(2, 32'hAAAA_AAAA);
    step("t13", 3'b101, 3'b000, 2'b11, 2'b00, 10, 8, 0, 0, 0, 0);

    set_r(1, 2, 0);
    rreq = 3'b011;
    step("pre_rst", 3'b011, 3'b000, 2'b11, 2'b00, 2, 1, 0, 0, 0, 0);
    rst = 1'b0;
    check_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);

    rst = 1'b1;
    set_r(1, 2, 3);
    rreq = 3'b111;
    push(0, da(1)); push(1, da(2));
    step("post_rst", 3'b011, 3'b000, 2'b11, 2'b00, 1, 2, 0, 0, 0, 0);
    rreq = 3'b000;
    set_r(0, 0, 0);
    step("idle1", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step("idle2", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    chk("pending_returns", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
